// File: rtl/booth_mac_arbiter_if.sv
// Request/result bundle between the PE array, the arbiter and the shared multiplier.
// The master side drives requests, the multiplier product and result back-pressure.
interface booth_mac_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
);
  logic [N_REQ-1:0]    req_valid;
  logic [N_REQ-1:0]    req_ready;
  logic [N_REQ-1:0]    req_acc;
  logic [16*N_REQ-1:0] req_a;
  logic [16*N_REQ-1:0] req_b;
  logic [15:0]         mul_a;
  logic [15:0]         mul_b;
  logic [31:0]         mul_p;
  logic                res_valid;
  logic                res_ready;
  logic [31:0]         res_data;
  logic [ID_W-1:0]     res_id;
  logic                busy;

  modport master (
    output req_valid, req_acc, req_a, req_b, mul_p, res_ready,
    input  req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );

  modport slave (
    input  req_valid, req_acc, req_a, req_b, mul_p, res_ready,
    output req_ready, mul_a, mul_b, res_valid, res_data, res_id, busy
  );
endinterface

// File: rtl/booth_mac_arbiter.sv
// Round-robin share of one 16x16 signed multiplier with per-requester accumulators.
// Define BOOTH_MAC_ARB_SAT_EN to saturate accumulate-mode sums instead of wrapping.
module booth_mac_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  booth_mac_arbiter_if.slave  bus
);

  logic [ID_W-1:0] ptr_q, ptr_d;
  logic            s1_vld_q, s1_vld_d;
  logic [ID_W-1:0] s1_id_q, s1_id_d;
  logic            s1_acc_q, s1_acc_d;
  logic [15:0]     mul_a_q, mul_a_d;
  logic [15:0]     mul_b_q, mul_b_d;
  logic            res_valid_q, res_valid_d;
  logic [31:0]     res_data_q, res_data_d;
  logic [ID_W-1:0] res_id_q, res_id_d;
  logic [31:0]     acc_q [N_REQ];

  logic            s1_rdy, s2_rdy, s2_fire, xfer;
  logic            grant_vld;
  logic [ID_W-1:0] grant_idx;
  logic [31:0]     acc_sel, add_raw, acc_sum, sum;

  assign s2_rdy  = !res_valid_q || bus.res_ready;
  assign s1_rdy  = !s1_vld_q || s2_rdy;
  assign s2_fire = s1_vld_q && s2_rdy;
  assign xfer    = grant_vld && s1_rdy;

  // First valid requester at or after the pointer, wrapping modulo N_REQ.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!grant_vld && bus.req_valid[(int'(ptr_q) + k) % N_REQ]) begin
        grant_vld = 1'b1;
        grant_idx = ID_W'((int'(ptr_q) + k) % N_REQ);
      end
    end
  end

  always_comb begin
    bus.req_ready = '0;
    if (grant_vld && !rst) bus.req_ready[grant_idx] = s1_rdy;
  end

  assign acc_sel = acc_q[s1_id_q];
  assign add_raw = acc_sel + bus.mul_p;

`ifdef BOOTH_MAC_ARB_SAT_EN
  logic ovf_pos, ovf_neg;
  assign ovf_pos = !acc_sel[31] && !bus.mul_p[31] && add_raw[31];
  assign ovf_neg = acc_sel[31] && bus.mul_p[31] && !add_raw[31];
  assign acc_sum = ovf_pos ? 32'h7FFF_FFFF : (ovf_neg ? 32'h8000_0000 : add_raw);
`else
  assign acc_sum = add_raw;
`endif

  assign sum = s1_acc_q ? acc_sum : bus.mul_p;

  always_comb begin
    ptr_d       = ptr_q;
    s1_vld_d    = s1_vld_q;
    s1_id_d     = s1_id_q;
    s1_acc_d    = s1_acc_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_id_d    = res_id_q;

    if (xfer) begin
      ptr_d    = ID_W'((int'(grant_idx) + 1) % N_REQ);
      mul_a_d  = bus.req_a[int'(grant_idx)*16 +: 16];
      mul_b_d  = bus.req_b[int'(grant_idx)*16 +: 16];
      s1_id_d  = grant_idx;
      s1_acc_d = bus.req_acc[grant_idx];
      s1_vld_d = 1'b1;
    end else if (s1_rdy) begin
      s1_vld_d = 1'b0;
    end

    if (s2_fire) begin
      res_data_d  = sum;
      res_id_d    = s1_id_q;
      res_valid_d = 1'b1;
    end else if (s2_rdy) begin
      res_valid_d = 1'b0;
    end
  end

  // The accumulator is written as the item leaves stage 1, so a following
  // same-id item already sees the updated value without forwarding.
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q       <= '0;
      s1_vld_q    <= 1'b0;
      s1_id_q     <= '0;
      s1_acc_q    <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_id_q    <= '0;
      for (int i = 0; i < N_REQ; i++) acc_q[i] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      s1_vld_q    <= s1_vld_d;
      s1_id_q     <= s1_id_d;
      s1_acc_q    <= s1_acc_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_id_q    <= res_id_d;
      if (s2_fire) acc_q[s1_id_q] <= sum;
    end
  end

  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.res_id    = res_id_q;
  assign bus.busy      = s1_vld_q || res_valid_q;

endmodule
